mac_accumulator: RTL and testbench

Streaming multiply-accumulate stage for the MAC datapath. It captures unsigned 8-bit operand pairs through a valid/ready handshake and forms each 16-bit product with the existing combinational Wallace multiplier. It registers the product and accumulates it into a saturating ACC_W-bit sum. When the element marked last is accumulated, the block emits the dot-product result on a single-entry output register with its own valid/ready handshake.

---
 rtl/mac_accumulator.sv | 130 +++++++++++++
 tb/tb_mac_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Streaming 8x8 unsigned multiply-accumulate: Wallace-tree product register feeding a
// saturating ACC_W-bit accumulator, with a one-entry result register on the output side.

module wallace_mult_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? ({8'd0, a} << i) : 16'd0;
    end
  end

  // Carry-save reduction 8 -> 6 -> 4 -> 3 -> 2 rows; the product fits in 16 bits,
  // so dropping carries out of bit 15 cannot change the result.
  assign s0 = pp[0] ^ pp[1] ^ pp[2];
  assign c0 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign s1 = pp[3] ^ pp[4] ^ pp[5];
  assign c1 = ((pp[3] & pp[4]) | (pp[3] & pp[5]) | (pp[4] & pp[5])) << 1;

  assign s2 = s0 ^ c0 ^ s1;
  assign c2 = ((s0 & c0) | (s0 & s1) | (c0 & s1)) << 1;
  assign s3 = c1 ^ pp[6] ^ pp[7];
  assign c3 = ((c1 & pp[6]) | (c1 & pp[7]) | (pp[6] & pp[7])) << 1;

  assign s4 = s2 ^ c2 ^ s3;
  assign c4 = ((s2 & c2) | (s2 & s3) | (c2 & s3)) << 1;

  assign s5 = s4 ^ c4 ^ c3;
  assign c5 = ((s4 & c4) | (s4 & c3) | (c4 & c3)) << 1;

  assign p = s5 + c5;

endmodule

module mac_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  logic [15:0]      prod;
  logic [15:0]      p_q;
  logic             p_last;
  logic             p_valid;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             stall;
  logic             accept;
  logic             acc_en;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] result;
  logic             ovf_next;

  wallace_mult_8x8 u_mult (
    .a (in_a),
    .b (in_b),
    .p (prod)
  );

  // Only a finished vector waiting behind an undelivered result can stall the pipe.
  assign stall    = p_valid && p_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign acc_en   = p_valid && !stall;

  assign sum      = {1'b0, acc} + {{(ACC_W-15){1'b0}}, p_q};
  assign result   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign ovf_next = sum[ACC_W] | ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      p_last  <= 1'b0;
      p_valid <= 1'b0;
    end else if (accept) begin
      p_q     <= prod;
      p_last  <= in_last;
      p_valid <= 1'b1;
    end else if (!stall) begin
      p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      if (p_last) begin
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= result;
        ovf <= ovf_next;
      end
    end
  end

  // A new result may replace one being consumed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (acc_en && p_last) begin
      out_valid <= 1'b1;
      out_acc   <= result;
      out_ovf   <= ovf_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator: streaming table of vectors plus
// hand-written reset, saturation and backpressure sequences.

module tb_mac_accumulator;

  localparam int ACC_W = 24;
  localparam int NV    = 7;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic             last;
    logic [ACC_W-1:0] exp_acc;
    logic             exp_ovf;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  int   pass_cnt;
  int   total_cnt;
  vec_t tbl [NV];

  mac_accumulator #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] a,
                               input logic [7:0] b, input logic last);
    in_valid = valid;
    in_a     = a;
    in_b     = b;
    in_last  = last;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string name, input logic [ACC_W-1:0] acc,
                             input logic ovf);
    checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, " acc"}, 32'(out_acc), 32'(acc));
    checkOutput({name, " ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  task automatic sendBeats(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, a, b, (i == n - 1));
      step();
    end
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    tbl[0] = '{8'd3,   8'd4,   1'b0, 24'd0,     1'b0};
    tbl[1] = '{8'd5,   8'd6,   1'b0, 24'd0,     1'b0};
    tbl[2] = '{8'd255, 8'd255, 1'b1, 24'd65067, 1'b0};
    tbl[3] = '{8'd255, 8'd255, 1'b1, 24'd65025, 1'b0};
    tbl[4] = '{8'd0,   8'd17,  1'b1, 24'd0,     1'b0};
    tbl[5] = '{8'd1,   8'd1,   1'b1, 24'd1,     1'b0};
    tbl[6] = '{8'd2,   8'd2,   1'b1, 24'd4,     1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    step();
    step();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_acc", 32'(out_acc), 32'd0);
    checkOutput("reset out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Beat i is accepted on step i; its result is visible after step i+1.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) applyStimulus(1'b1, tbl[i].a, tbl[i].b, tbl[i].last);
      else        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      step();
      checkOutput($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'd1);
      if (i > 0 && tbl[i-1].last) begin
        checkResult($sformatf("stream vec %0d", i - 1), tbl[i-1].exp_acc, tbl[i-1].exp_ovf);
      end else begin
        checkOutput($sformatf("stream idle %0d", i), 32'(out_valid), 32'd0);
      end
    end

    // Asynchronous reset while a result is held and a beat is being offered.
    applyStimulus(1'b1, 8'd7, 8'd7, 1'b1);
    step();
    step();
    checkResult("pre-reset", 24'd49, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset out_acc", 32'(out_acc), 32'd0);
    checkOutput("async reset out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    sendBeats(1, 8'd2, 8'd2);
    step();
    checkResult("post-reset 2x2", 24'd4, 1'b0);

    // Saturation boundary: 258 products fit, 260 saturate, next vector starts clean.
    sendBeats(258, 8'd255, 8'd255);
    step();
    checkResult("258 x 65025", 24'd16776450, 1'b0);
    sendBeats(260, 8'd255, 8'd255);
    step();
    checkResult("260 x 65025", 24'hFFFFFF, 1'b1);
    sendBeats(1, 8'd1, 8'd1);
    step();
    checkResult("after saturation", 24'd1, 1'b0);
    step();

    // Backpressure: A held, B's last stalls stage P, C waits at the input.
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'd10, 8'd10, 1'b1);
    step();
    applyStimulus(1'b1, 8'd2, 8'd3, 1'b0);
    step();
    checkResult("bp A loaded", 24'd100, 1'b0);
    checkOutput("bp in_ready before B last", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 8'd4, 8'd5, 1'b1);
    step();
    checkOutput("bp in_ready stalled", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 8'd1, 8'd3, 1'b1);
    step();
    step();
    checkResult("bp A held", 24'd100, 1'b0);
    checkOutput("bp in_ready still stalled", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready comb rise", 32'(in_ready), 32'd1);
    step();
    checkResult("bp B delivered", 24'd26, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    step();
    checkResult("bp C delivered", 24'd3, 1'b0);
    step();
    checkOutput("bp drained", 32'(out_valid), 32'd0);

    // Mid-vector reset drops the partial sum.
    sendBeats(1, 8'd100, 8'd100);
    applyStimulus(1'b1, 8'd100, 8'd100, 1'b0);
    step();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sendBeats(1, 8'd1, 8'd2);
    step();
    checkResult("mid-vector reset", 24'd2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
